// File: rtl/ctrl_delay_pipe_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_delay_pipe_pkg
//   Shared types and constants for the control delay line.
//   - ctrl_reg     : packed start/valid/stop word carried on the control bus
//   - CTRL_IDLE    : all-zero control word
//   - D_BIAS/D_ACT/D_POOL : datapath stage latencies the delay line is
//                    typically configured to match
//   - ctrl_any()   : true when any control bit of a word is set
// -----------------------------------------------------------------------------
package ctrl_delay_pipe_pkg;

   typedef struct packed {
      logic start;
      logic valid;
      logic stop;
   } ctrl_reg;

   localparam ctrl_reg CTRL_IDLE = '{start: 1'b0, valid: 1'b0, stop: 1'b0};

   localparam int unsigned D_BIAS = 32'd3;
   localparam int unsigned D_ACT  = 32'd2;
   localparam int unsigned D_POOL = 32'd4;

   function automatic logic ctrl_any(input ctrl_reg w);
      return w.start | w.valid | w.stop;
   endfunction

endpackage

// File: rtl/ctrl_frame_track.sv
// -----------------------------------------------------------------------------
// ctrl_frame_track
//   Frame bookkeeping for the control delay line: in-flight frame counter,
//   busy flag, output beat counter and (optionally) a sticky protocol checker.
//   Optional feature macro: CTRL_DELAY_PIPE_CHECK_EN (adds in_word and err).
//
//   clk       in   clock
//   xrst      in   synchronous active-low reset
//   stall     in   pipeline freeze; no word is accepted while high
//   in_start  in   raw upstream start bit
//   out_word  in   word emitted at the pipe output (already zero when stalled)
//   busy      out  at least one frame in flight
//   beat_cnt  out  valid beats emitted in the current output frame
//   in_word   in   raw upstream word (checker build only)
//   err       out  sticky protocol error (checker build only)
// -----------------------------------------------------------------------------
module ctrl_frame_track
   import ctrl_delay_pipe_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int CNT_W = 16
)
(
   input  logic             clk,
   input  logic             xrst,
   input  logic             stall,
   input  logic             in_start,
   input  ctrl_reg          out_word,
   output logic             busy,
   output logic [CNT_W-1:0] beat_cnt
`ifdef CTRL_DELAY_PIPE_CHECK_EN
   ,
   input  ctrl_reg          in_word,
   output logic             err
`endif
);

   localparam int INF_W = $clog2(DEPTH + 1) + 1;

   localparam logic [INF_W-1:0] INF_ZERO = {INF_W{1'b0}};
   localparam logic [INF_W-1:0] INF_ONE  = {{(INF_W-1){1'b0}}, 1'b1};
   localparam logic [INF_W-1:0] INF_MAX  = {INF_W{1'b1}};
   localparam logic [CNT_W-1:0] BEAT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] BEAT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] BEAT_MAX  = {CNT_W{1'b1}};

   logic [INF_W-1:0] inflight_r;
   logic [INF_W-1:0] inflight_nxt_s;
   logic [CNT_W-1:0] beat_r;
   logic [CNT_W-1:0] beat_nxt_s;
   logic             acc_start_s;
   logic             out_stop_s;

   // A start only counts when it is actually captured into stage 0.
   assign acc_start_s = in_start & ~stall;
   assign out_stop_s  = out_word.stop;

   // In-flight frame count: +1 per accepted start, -1 per emitted stop.
   always_comb begin
      inflight_nxt_s = inflight_r;
      if (acc_start_s && !out_stop_s) begin
         if (inflight_r != INF_MAX) begin
            inflight_nxt_s = inflight_r + INF_ONE;
         end else begin
            inflight_nxt_s = inflight_r;
         end
      end else if (out_stop_s && !acc_start_s) begin
         if (inflight_r != INF_ZERO) begin
            inflight_nxt_s = inflight_r - INF_ONE;
         end else begin
            inflight_nxt_s = inflight_r;
         end
      end else begin
         inflight_nxt_s = inflight_r;
      end
   end

   // Beat counter: reload on output start, saturating count of output valids.
   always_comb begin
      beat_nxt_s = beat_r;
      if (out_word.start) begin
         beat_nxt_s = out_word.valid ? BEAT_ONE : BEAT_ZERO;
      end else if (out_word.valid && (beat_r != BEAT_MAX)) begin
         beat_nxt_s = beat_r + BEAT_ONE;
      end else begin
         beat_nxt_s = beat_r;
      end
   end

   // Counter state registers.
   always_ff @(posedge clk) begin
      if (!xrst) begin
         inflight_r <= INF_ZERO;
         beat_r     <= BEAT_ZERO;
      end else begin
         inflight_r <= inflight_nxt_s;
         beat_r     <= beat_nxt_s;
      end
   end

   assign busy     = (inflight_r != INF_ZERO);
   assign beat_cnt = beat_r;

`ifdef CTRL_DELAY_PIPE_CHECK_EN
   logic frame_open_r;
   logic frame_open_nxt_s;
   logic proto_err_s;
   logic ovf_s;
   logic err_r;

   assign ovf_s = acc_start_s & ~out_stop_s & (inflight_r == INF_MAX);

   // Input-side frame tracking and protocol violation detection.
   always_comb begin
      frame_open_nxt_s = frame_open_r;
      proto_err_s      = 1'b0;
      if (stall) begin
         proto_err_s      = ctrl_any(in_word);
         frame_open_nxt_s = frame_open_r;
      end else if (in_word.start) begin
         // A start+stop word is a complete one-beat frame.
         proto_err_s      = frame_open_r;
         frame_open_nxt_s = ~in_word.stop;
      end else if (in_word.valid || in_word.stop) begin
         proto_err_s      = ~frame_open_r;
         frame_open_nxt_s = frame_open_r & ~in_word.stop;
      end else begin
         proto_err_s      = 1'b0;
         frame_open_nxt_s = frame_open_r;
      end
   end

   // Frame-open flag and sticky error register.
   always_ff @(posedge clk) begin
      if (!xrst) begin
         frame_open_r <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         frame_open_r <= frame_open_nxt_s;
         err_r        <= err_r | proto_err_s | ovf_s;
      end
   end

   assign err = err_r;
`endif

endmodule

// File: rtl/ctrl_delay_pipe.sv
// -----------------------------------------------------------------------------
// ctrl_delay_pipe
//   Parametrised DEPTH-cycle delay line for the start/valid/stop control word,
//   with N_TAP early output-enable taps, global stall and frame tracking.
//   Optional feature macro: CTRL_DELAY_PIPE_CHECK_EN (adds sticky err output).
//
//   clk       in   clock
//   xrst      in   synchronous active-low reset
//   in_ctrl   in   start/valid/stop from upstream
//   out_ctrl  out  in_ctrl delayed by DEPTH cycles, zero while stalled
//   stall     in   freeze all stages; in_ctrl is dropped
//   oe        out  oe[k] = valid of the word reaching out_ctrl in k+1 cycles
//   busy      out  at least one frame in flight
//   beat_cnt  out  valid beats emitted in the current output frame
//   err       out  sticky protocol error (CTRL_DELAY_PIPE_CHECK_EN only)
// -----------------------------------------------------------------------------
module ctrl_delay_pipe
   import ctrl_delay_pipe_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int N_TAP = 1,
   parameter int CNT_W = 16
)
(
   input  logic             clk,
   input  logic             xrst,
   input  ctrl_reg          in_ctrl,
   output ctrl_reg          out_ctrl,
   input  logic             stall,
   output logic [N_TAP-1:0] oe,
   output logic             busy,
   output logic [CNT_W-1:0] beat_cnt
`ifdef CTRL_DELAY_PIPE_CHECK_EN
   ,
   output logic             err
`endif
);

   genvar i;
   genvar k;

   generate
      for (i = 0; i < DEPTH; i++) begin : g_stage
         ctrl_reg d_s;
         ctrl_reg q_r;

         if (i == 0) begin : g_head
            assign d_s = in_ctrl;
         end else begin : g_body
            assign d_s = g_stage[i-1].q_r;
         end

         // One delay stage; holds while stalled.
         always_ff @(posedge clk) begin
            if (!xrst) begin
               q_r <= CTRL_IDLE;
            end else if (!stall) begin
               q_r <= d_s;
            end else begin
               q_r <= q_r;
            end
         end
      end
   endgenerate

   // While stalled the last stage is held, so the output is blanked to avoid
   // downstream seeing the same beat twice.
   assign out_ctrl = stall ? CTRL_IDLE : g_stage[DEPTH-1].q_r;

   generate
      for (k = 0; k < N_TAP; k++) begin : g_tap
         assign oe[k] = g_stage[DEPTH-2-k].q_r.valid & ~stall;
      end
   endgenerate

   ctrl_frame_track #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_track (
      .clk      (clk),
      .xrst     (xrst),
      .stall    (stall),
      .in_start (in_ctrl.start),
      .out_word (out_ctrl),
      .busy     (busy),
      .beat_cnt (beat_cnt)
`ifdef CTRL_DELAY_PIPE_CHECK_EN
      ,
      .in_word  (in_ctrl),
      .err      (err)
`endif
   );

endmodule

// File: tb/tb_ctrl_delay_pipe.sv
// -----------------------------------------------------------------------------
// tb_ctrl_delay_pipe
//   Drives two delay lines (DEPTH=3/N_TAP=1 and DEPTH=5/N_TAP=3) with the same
//   control stream. Every accepted input word is queued per instance; the queue
//   front is the word due at out_ctrl, later entries predict the oe taps.
// -----------------------------------------------------------------------------
module tb_ctrl_delay_pipe;
   import ctrl_delay_pipe_pkg::*;

   localparam logic [2:0] W_I   = 3'b000;
   localparam logic [2:0] W_V   = 3'b010;
   localparam logic [2:0] W_SV  = 3'b110;
   localparam logic [2:0] W_VS  = 3'b011;
   localparam logic [2:0] W_SVS = 3'b111;

   logic        clk = 1'b0;
   logic        xrst;
   ctrl_reg     in_ctrl;
   logic        stall;
   ctrl_reg     out3, out5;
   logic [0:0]  oe3;
   logic [2:0]  oe5;
   logic        busy3, busy5;
   logic [15:0] beat3, beat5;
`ifdef CTRL_DELAY_PIPE_CHECK_EN
   logic        err3, err5;
   logic        exp_err = 1'b0;
`endif

   int          total = 0;
   int          bad = 0;
   bit          chk_en = 1'b0;

   ctrl_reg     mq [2][$];
   int          dep [2] = '{3, 5};
   int          ntap [2] = '{1, 3};
   int          minf [2];
   logic [15:0] mbeat [2];

   always #5 clk = ~clk;

   ctrl_delay_pipe #(.DEPTH(3), .N_TAP(1), .CNT_W(16)) u_d3 (
      .clk      (clk),
      .xrst     (xrst),
      .in_ctrl  (in_ctrl),
      .out_ctrl (out3),
      .stall    (stall),
      .oe       (oe3),
      .busy     (busy3),
      .beat_cnt (beat3)
`ifdef CTRL_DELAY_PIPE_CHECK_EN
      ,
      .err      (err3)
`endif
   );

   ctrl_delay_pipe #(.DEPTH(5), .N_TAP(3), .CNT_W(16)) u_d5 (
      .clk      (clk),
      .xrst     (xrst),
      .in_ctrl  (in_ctrl),
      .out_ctrl (out5),
      .stall    (stall),
      .oe       (oe5),
      .busy     (busy5),
      .beat_cnt (beat5)
`ifdef CTRL_DELAY_PIPE_CHECK_EN
      ,
      .err      (err5)
`endif
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare both instances against the scoreboard (called mid-cycle).
   task automatic check_all();
      ctrl_reg     eo, oo;
      logic [3:0]  eoe, ooe;
      logic        ob;
      logic [15:0] obt;
      for (int n = 0; n < 2; n++) begin
         if (n == 0) begin
            oo = out3; ooe = {3'b000, oe3}; ob = busy3; obt = beat3;
         end else begin
            oo = out5; ooe = {1'b0, oe5}; ob = busy5; obt = beat5;
         end
         eo  = stall ? ctrl_reg'(3'b000) : mq[n][0];
         eoe = 4'b0000;
         for (int k = 0; k < ntap[n]; k++)
            eoe[k] = stall ? 1'b0 : mq[n][k+1].valid;
         chk($sformatf("d%0d_out", dep[n]), {13'd0, oo}, {13'd0, eo});
         chk($sformatf("d%0d_oe", dep[n]), {12'd0, ooe}, {12'd0, eoe});
         chk($sformatf("d%0d_busy", dep[n]), {15'd0, ob}, {15'd0, (minf[n] != 0)});
         chk($sformatf("d%0d_beat", dep[n]), obt, mbeat[n]);
      end
`ifdef CTRL_DELAY_PIPE_CHECK_EN
      chk("d3_err", {15'd0, err3}, {15'd0, exp_err});
      chk("d5_err", {15'd0, err5}, {15'd0, exp_err});
`endif
   endtask

   // Scoreboard update at the clock edge: pop the emitted word, push the new one.
   task automatic model_edge(input ctrl_reg w);
      ctrl_reg em;
      for (int n = 0; n < 2; n++) begin
         if (!xrst) begin
            mq[n].delete();
            repeat (dep[n]) mq[n].push_back(ctrl_reg'(3'b000));
            minf[n]  = 0;
            mbeat[n] = 16'd0;
         end else if (!stall) begin
            em = mq[n].pop_front();
            mq[n].push_back(w);
            if (w.start && !em.stop) minf[n]++;
            else if (em.stop && !w.start) minf[n]--;
            if (em.start) mbeat[n] = {15'd0, em.valid};
            else if (em.valid && mbeat[n] != 16'hFFFF) mbeat[n]++;
         end
      end
   endtask

   task automatic cyc(input logic [2:0] w, input logic st, input logic rst);
      xrst    = rst;
      in_ctrl = w;
      stall   = st;
      @(negedge clk);
      if (chk_en) check_all();
      @(posedge clk);
      model_edge(w);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(W_I, 1'b0, 1'b1);
   endtask

   initial begin
      xrst = 1'b0; in_ctrl = W_I; stall = 1'b0;
      cyc(W_I, 1'b0, 1'b0);
      cyc(W_I, 1'b0, 1'b0);
      chk_en = 1'b1;

      // Reset state
      chk("rst_out3", {13'd0, out3}, 16'd0);
      chk("rst_oe5", {13'd0, oe5}, 16'd0);
      chk("rst_busy3", {15'd0, busy3}, 16'd0);
      chk("rst_beat5", beat5, 16'd0);
      idle(2);

      // Six-beat frame, no stall
      cyc(W_SV, 1'b0, 1'b1);
      repeat (4) cyc(W_V, 1'b0, 1'b1);
      cyc(W_VS, 1'b0, 1'b1);
      idle(8);
      chk("t1_beat3", beat3, 16'd6);
      chk("t1_beat5", beat5, 16'd6);
      chk("t1_busy3", {15'd0, busy3}, 16'd0);

      // Single one-beat frame (taps ripple toward output)
      cyc(W_SVS, 1'b0, 1'b1);
      idle(8);
      chk("t2_beat5", beat5, 16'd1);

      // Eight-beat frame with a 3-cycle stall in the middle
      cyc(W_SV, 1'b0, 1'b1);
      cyc(W_V, 1'b0, 1'b1);
      cyc(W_V, 1'b0, 1'b1);
      repeat (3) cyc(W_I, 1'b1, 1'b1);
      repeat (4) cyc(W_V, 1'b0, 1'b1);
      cyc(W_VS, 1'b0, 1'b1);
      idle(10);
      chk("stall_beat3", beat3, 16'd8);
      chk("stall_beat5", beat5, 16'd8);

      // Back-to-back two-beat frames
      cyc(W_SV, 1'b0, 1'b1);
      cyc(W_VS, 1'b0, 1'b1);
      cyc(W_SV, 1'b0, 1'b1);
      cyc(W_VS, 1'b0, 1'b1);
      idle(10);
      chk("b2b_beat3", beat3, 16'd2);
      chk("b2b_busy5", {15'd0, busy5}, 16'd0);

      // Reset with words in flight
      cyc(W_SV, 1'b0, 1'b1);
      cyc(W_V, 1'b0, 1'b1);
      cyc(W_V, 1'b0, 1'b1);
      cyc(W_I, 1'b0, 1'b0);
      chk("mrst_out5", {13'd0, out5}, 16'd0);
      chk("mrst_busy3", {15'd0, busy3}, 16'd0);
      chk("mrst_busy5", {15'd0, busy5}, 16'd0);
      chk("mrst_beat3", beat3, 16'd0);
      idle(10);

`ifdef CTRL_DELAY_PIPE_CHECK_EN
      // Second start before stop sets the sticky error
      cyc(W_SV, 1'b0, 1'b1);
      cyc(W_SV, 1'b0, 1'b1);
      exp_err = 1'b1;
      idle(10);
      cyc(W_I, 1'b0, 1'b0);
      exp_err = 1'b0;
      idle(3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
